// File: rtl/pcie_tl_pkg.sv
// Shared PCIe transaction-layer definitions for the classifier/arbiter path:
// VC count, class field width, classifier state encoding and one-hot helper.
package pcie_tl_pkg;
  localparam int VC_NUM  = 4;
  localparam int CLASS_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLOCK = 2'd2
  } dmx_state_e;

  function automatic logic [VC_NUM-1:0] onehot4(input logic [CLASS_W-1:0] cls);
    logic [VC_NUM-1:0] oh;
    oh = 4'b0001 << cls;
    return oh;
  endfunction
endpackage

// File: rtl/vc_contador.sv
// Occupancy counter and level flags for one VC FIFO; full_nx exposes the
// post-edge full condition so the classifier can decide BLOCK at the same edge.
module vc_contador #(
  parameter int DEPTH  = 8,
  parameter int AF_THR = 6,
  parameter int AE_THR = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             full_nx,
  output logic             empty,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             pop_err
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_ok;

  // Pops on an empty FIFO are dropped, so the count can never wrap below zero.
  assign pop_ok  = pop && (cnt_q != '0);
  assign pop_err = pop && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_L) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count        = cnt_q;
  assign full_nx      = (cnt_d == CNT_W'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_empty = (cnt_q <= CNT_W'(AE_THR));
  assign almost_full  = (cnt_q >= CNT_W'(AF_THR));
endmodule

// File: rtl/demux_clasificador.sv
// Classifies incoming TLP words into 4 VC FIFOs by their top class bits and
// tracks per-FIFO occupancy. Optional error counter: DEMUX_ERR_CNT_EN.
module demux_clasificador
  import pcie_tl_pkg::*;
#(
  parameter  int DATA_W = 10,
  parameter  int DEPTH  = 8,
  parameter  int AF_THR = 6,
  parameter  int AE_THR = 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic [3:0]              pop_fifo,
  output logic [3:0]              push_fifo,
  output logic [DATA_W-1:0]       data_fifo,
  output logic [3:0]              empty,
  output logic [3:0]              almost_empty,
  output logic [3:0]              almost_full,
  output logic [4*CNT_W-1:0]      count_flat,
  output logic [7:0]              err_cnt
);
  dmx_state_e          st_q, st_d;
  logic [DATA_W-1:0]   h_data_q, h_data_d;
  logic [VC_NUM-1:0]   push_q;
  logic [DATA_W-1:0]   data_q;
  logic [CLASS_W-1:0]  cls, in_cls;
  logic                h_valid, can_issue, accept;
  logic [VC_NUM-1:0]   issue_vec, full_nx, pop_err;

  assign cls    = h_data_q[DATA_W-1 -: CLASS_W];
  assign in_cls = in_data[DATA_W-1 -: CLASS_W];
  assign accept = in_valid && in_ready;

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    vc_contador #(.DEPTH(DEPTH), .AF_THR(AF_THR), .AE_THR(AE_THR), .CNT_W(CNT_W)) u_cnt (
      .clk          (clk),
      .reset_L      (reset_L),
      .push         (issue_vec[g]),
      .pop          (pop_fifo[g]),
      .count        (count_flat[g*CNT_W +: CNT_W]),
      .full_nx      (full_nx[g]),
      .empty        (empty[g]),
      .almost_empty (almost_empty[g]),
      .almost_full  (almost_full[g]),
      .pop_err      (pop_err[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset_L) st_q <= IDLE;
    else         st_q <= st_d;
  end

  // LOAD/BLOCK is decided from the post-edge count, so the registered state
  // always equals "h_valid && count[cls] < DEPTH" on the registered counts.
  always_comb begin
    st_d     = st_q;
    h_data_d = h_data_q;
    if (accept) begin
      h_data_d = in_data;
      st_d     = full_nx[in_cls] ? BLOCK : LOAD;
    end else begin
      case (st_q)
        LOAD:    st_d = IDLE;
        BLOCK:   st_d = full_nx[cls] ? BLOCK : LOAD;
        default: st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    h_valid   = (st_q != IDLE);
    can_issue = (st_q == LOAD);
    in_ready  = !h_valid || can_issue;
    issue_vec = can_issue ? onehot4(cls) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset_L) begin
      h_data_q <= '0;
      push_q   <= '0;
      data_q   <= '0;
    end else begin
      h_data_q <= h_data_d;
      push_q   <= issue_vec;
      if (can_issue) data_q <= h_data_q;
    end
  end

  assign push_fifo = push_q;
  assign data_fifo = data_q;

`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_q;
  logic       err_ev;

  assign err_ev = (|pop_err) || (in_valid && st_q == BLOCK);

  always_ff @(posedge clk) begin
    if (reset_L)                      err_q <= '0;
    else if (err_ev && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`else
  logic unused_pop_err;
  assign unused_pop_err = ^pop_err;
  assign err_cnt        = '0;
`endif
endmodule
